// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if
// Frame handshake between the CPU (master) and the display scan controller
// (slave). A frame is transferred on any cycle where frame_valid and
// frame_ready are both high.
interface display_scan_controller_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [19:0] frame_data;

  modport master (
    output frame_valid,
    output frame_data,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    output frame_ready
  );
endinterface

// File: rtl/display_scan_controller.sv
// display_scan_controller
// Four-digit seven-segment scan sequencer with a double-buffered frame store.
// Each digit slot is TICK_DIV cycles: BLANK_CYCLES with all digits off, then
// the selected digit driven (one-cold enables). A new frame waits in the
// pending buffer and is copied to the active buffer only at the end of the
// digit-3 slot, so a displayed frame never mixes two CPU frames.
// Optional macro DISPLAY_DIM_EN adds a 4-bit brightness input that PWMs the
// driven digit with a free-running 4-bit counter.
module display_scan_controller #(
  parameter int TICK_DIV     = 250000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            reset,
  display_scan_controller_if.slave        frame_if,
`ifdef DISPLAY_DIM_EN
  input  logic [3:0]                      brightness,
`endif
  output logic [4:0]                      num_out,
  output logic [1:0]                      digit_sel,
  output logic [3:0]                      enable,
  output logic                            frame_done
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    r_sel;
  logic [1:0]    w_sel_next;
  logic          w_slot_end;
  logic          w_frame_done;
  logic [3:0]    w_enable;
  logic          w_drive_on;

  logic [19:0]   r_active;
  logic [19:0]   r_pending;
  logic          r_pending_full;
  logic [4:0]    r_num;
  logic [19:0]   w_src;
  logic [4:0]    w_num_next;
  logic          w_accept;
  logic          w_swap;

`ifdef DISPLAY_DIM_EN
  logic [3:0]    r_pwm;

  // Free-running PWM phase used to dim the driven digit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm <= 4'd0;
    end else begin
      r_pwm <= r_pwm + 4'd1;
    end
  end

  assign w_drive_on = (r_pwm < brightness);
`else
  assign w_drive_on = 1'b1;
`endif

  // Scan state, slot counter and digit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_sel   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sel   <= w_sel_next;
    end
  end

  // Next-state logic and enables: blank first, then drive, advance digit at slot end
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + CW'(1);
    w_sel_next   = r_sel;
    w_slot_end   = 1'b0;
    w_enable     = 4'b1111;
    case (r_state)
      BLANK: begin
        if (r_cnt == BLANK_END) begin
          w_state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (w_drive_on) begin
          w_enable = ~(4'b0001 << r_sel);
        end
        if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_sel_next   = r_sel + 2'd1;
          w_state_next = BLANK;
          w_slot_end   = 1'b1;
        end
      end
      default: begin
        w_state_next = BLANK;
      end
    endcase
    w_frame_done = w_slot_end && (r_sel == 2'd3);
  end

  assign w_accept = frame_if.frame_valid && !r_pending_full;
  assign w_swap   = w_frame_done && r_pending_full;

  // Pick the digit code for the slot being entered, from the new frame on a swap
  always_comb begin
    w_src      = w_swap ? r_pending : r_active;
    w_num_next = w_src[4:0];
    case (w_sel_next)
      2'd0: w_num_next = w_src[4:0];
      2'd1: w_num_next = w_src[9:5];
      2'd2: w_num_next = w_src[14:10];
      2'd3: w_num_next = w_src[19:15];
      default: w_num_next = w_src[4:0];
    endcase
  end

  // Frame buffers: accept into pending, promote to active at the frame boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active       <= 20'd0;
      r_pending      <= 20'd0;
      r_pending_full <= 1'b0;
      r_num          <= 5'd0;
    end else begin
      if (w_accept) begin
        r_pending      <= frame_if.frame_data;
        r_pending_full <= 1'b1;
      end
      if (w_swap) begin
        r_active       <= r_pending;
        r_pending_full <= 1'b0;
      end
      if (w_slot_end) begin
        r_num <= w_num_next;
      end
    end
  end

  assign frame_if.frame_ready = !r_pending_full;
  assign num_out              = r_num;
  assign digit_sel            = r_sel;
  assign enable               = w_enable;
  assign frame_done           = w_frame_done;

endmodule
